// File: rtl/muldiv_if.sv
// muldiv_if: command/result bundle between the decode/RegFile side and the
// multiply/divide unit.
//   start, op, busa, busb, flush : command side (master -> slave)
//   busy, done, hi, lo           : status/result side (slave -> master)
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] busa;
    logic [WIDTH-1:0] busb;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, busa, busb, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, busa, busb, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : muldiv_if.slave
//     start/op/busa/busb : command strobe, opcode and RegFile operands
//     flush              : abort an in-flight operation (wins over FIX write)
//     busy               : state != IDLE, purely registered
//     done               : one-cycle pulse after HI/LO written by MULT*/DIV*
//     hi/lo              : HI/LO registers
// One shift-add or restoring-divide step per cycle for WIDTH cycles, then a
// FIX cycle applies sign correction and writes HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   reset,
    muldiv_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc;      // mul: {partial, multiplier}; div: low half = dividend/quotient
    logic [WIDTH:0]     rem;      // divide partial remainder, one guard bit for the trial subtract
    logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_p;    // negate product / quotient
    logic               neg_r;    // negate remainder (dividend sign)
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    // command decode
    logic             accept, op_arith, div_zero, last_iter;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept    = (state == IDLE) && bus.start && !bus.flush;
    assign op_arith  = !bus.op[2];
    assign div_zero  = bus.op[1] && (bus.busb == '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // op[0]=0 selects the signed variants
    assign a_neg = !bus.op[0] && bus.busa[WIDTH-1];
    assign b_neg = !bus.op[0] && bus.busb[WIDTH-1];
    assign a_mag = a_neg ? -bus.busa : bus.busa;
    assign b_mag = b_neg ? -bus.busb : bus.busb;

    // multiply step: conditional add into the upper half, then shift right
    // with the carry landing in the top bit
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // restoring divide step: shift next dividend bit in, trial subtract
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb};
    assign div_ok    = !div_diff[WIDTH+1];

    // FIX-cycle sign correction
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_raw, quo, rmd;
    assign prod    = neg_p ? -acc : acc;
    assign quo_raw = acc[WIDTH-1:0];
    assign quo     = neg_p ? -quo_raw : quo_raw;
    assign rmd     = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && op_arith) state_nxt = div_zero ? FIX : RUN;
            RUN: begin
                if (bus.flush)     state_nxt = IDLE;
                else if (last_iter) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            rem    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FIX) && !bus.flush;
            case (state)
                IDLE: if (accept) begin
                    case (bus.op)
                        3'b100: hi_q <= bus.busa;
                        3'b101: lo_q <= bus.busa;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            cnt    <= '0;
                            is_div <= bus.op[1];
                            if (div_zero) begin
                                // FIX then writes lo=all-ones, hi=raw dividend
                                acc   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                rem   <= {1'b0, bus.busa};
                                neg_p <= 1'b0;
                                neg_r <= 1'b0;
                            end else begin
                                neg_p <= a_neg ^ b_neg;
                                neg_r <= a_neg;
                                if (bus.op[1]) begin
                                    acc <= {{WIDTH{1'b0}}, a_mag};
                                    rem <= '0;
                                    opb <= b_mag;
                                end else begin
                                    acc <= {{WIDTH{1'b0}}, b_mag};
                                    opb <= a_mag;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                RUN: if (!bus.flush) begin
                    cnt <= last_iter ? '0 : cnt + CW'(1);
                    if (is_div) begin
                        acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ok};
                        rem <= div_ok ? div_diff[WIDTH:0] : div_shift;
                    end else begin
                        acc <= mul_next;
                    end
                end
                FIX: if (!bus.flush) begin
                    if (is_div) begin
                        lo_q <= quo;
                        hi_q <= rmd;
                    end else begin
                        {hi_q, lo_q} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // one-cycle command strobe; returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.busa  = a;
        bus.busb  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // issue and observe a 40-cycle window; index 0 = negedge after accept
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output int done_cnt, output int done_idx);
        issue(o, a, b);
        busy_cyc = 0;
        done_cnt = 0;
        done_idx = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", bus.hi, bus.lo);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        issue(OP_MTHI, 32'h12345678, 32'h0);
        issue(OP_MTLO, 32'h12345678, 32'h0);
        tests_run++;
        if (bus.hi !== 32'h12345678 || bus.lo !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL mthi_mtlo_preload: got hi=%h lo=%h expected 12345678/12345678", bus.hi, bus.lo);
        end
        issue(OP_MULT, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_midrun: got hi=%h lo=%h busy=%b expected 0/0/0", bus.hi, bus.lo, bus.busy);
        end
        @(negedge clk);
        reset = 1'b1;
        issue(OP_MTLO, 32'h5, 32'h0);
        tests_run++;
        if (bus.lo !== 32'h5 || bus.hi !== 32'h0) begin
            tests_failed++;
            $display("FAIL mtlo_after_reset: got hi=%h lo=%h expected 0/00000005", bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult;
        int bc, dc, di;
        run_op(OP_MULT, 32'hFFFFFFFE, 32'h3, bc, dc, di);
        tests_run++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA) begin
            tests_failed++;
            $display("FAIL mult_neg: got hi=%h lo=%h expected ffffffff/fffffffa", bus.hi, bus.lo);
        end
        tests_run++;
        if (bc !== 33 || dc !== 1 || di !== 33) begin
            tests_failed++;
            $display("FAIL mult_timing: got busy=%0d done_cnt=%0d done_idx=%0d expected 33/1/33", bc, dc, di);
        end
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc, di);
        tests_run++;
        if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
            tests_failed++;
            $display("FAIL multu_max: got hi=%h lo=%h expected fffffffe/00000001", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div;
        int bc, dc, di;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, bc, dc, di);
        tests_run++;
        if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL div_neg: got hi=%h lo=%h expected ffffffff/fffffffd", bus.hi, bus.lo);
        end
        tests_run++;
        if (bc !== 33 || dc !== 1 || di !== 33) begin
            tests_failed++;
            $display("FAIL div_timing: got busy=%0d done_cnt=%0d done_idx=%0d expected 33/1/33", bc, dc, di);
        end
        run_op(OP_DIVU, 32'd100, 32'd7, bc, dc, di);
        tests_run++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            tests_failed++;
            $display("FAIL divu_100_7: got hi=%h lo=%h expected 00000002/0000000e", bus.hi, bus.lo);
        end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dc, di);
        tests_run++;
        if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0) begin
            tests_failed++;
            $display("FAIL div_overflow: got hi=%h lo=%h expected 00000000/80000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_zero;
        int bc, dc, di;
        run_op(OP_DIVU, 32'h64, 32'h0, bc, dc, di);
        tests_run++;
        if (bus.lo !== 32'hFFFFFFFF || bus.hi !== 32'h64) begin
            tests_failed++;
            $display("FAIL divu_zero: got hi=%h lo=%h expected 00000064/ffffffff", bus.hi, bus.lo);
        end
        tests_run++;
        if (bc !== 1 || dc !== 1 || di !== 1) begin
            tests_failed++;
            $display("FAIL divzero_timing: got busy=%0d done_cnt=%0d done_idx=%0d expected 1/1/1", bc, dc, di);
        end
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h0, bc, dc, di);
        tests_run++;
        if (bus.lo !== 32'hFFFFFFFF || bus.hi !== 32'hFFFFFFF9) begin
            tests_failed++;
            $display("FAIL div_zero_signed: got hi=%h lo=%h expected fffffff9/ffffffff", bus.hi, bus.lo);
        end
    endtask

    task automatic test_start_while_busy;
        int bc, dc;
        logic [31:0] hi_mid;
        issue(OP_MULT, 32'd3, 32'd5);
        bc = 0;
        dc = 0;
        hi_mid = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) bc++;
            if (bus.done) dc++;
            if (i == 12) hi_mid = bus.hi;
            if (i == 10) begin
                bus.start = 1'b1;
                bus.op    = OP_MTHI;
                bus.busa  = 32'hDEAD;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        tests_run++;
        if (hi_mid !== 32'hFFFFFFF9) begin
            tests_failed++;
            $display("FAIL hi_stable_in_run: got hi=%h expected fffffff9", hi_mid);
        end
        tests_run++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
            tests_failed++;
            $display("FAIL mult_ignore_start: got hi=%h lo=%h expected 00000000/0000000f", bus.hi, bus.lo);
        end
        tests_run++;
        if (dc !== 1 || bc !== 33) begin
            tests_failed++;
            $display("FAIL ignore_start_timing: got done_cnt=%0d busy=%0d expected 1/33", dc, bc);
        end
    endtask

    task automatic test_flush;
        int bc, dc, di;
        logic busy20, busy21;
        issue(OP_MTHI, 32'hA, 32'h0);
        issue(OP_MTLO, 32'hB, 32'h0);
        issue(OP_DIVU, 32'd9, 32'd2);
        dc = 0;
        busy20 = 1'b0;
        busy21 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dc++;
            if (i == 20) busy20 = bus.busy;
            if (i == 21) busy21 = bus.busy;
            bus.flush = (i == 20);
            @(negedge clk);
        end
        tests_run++;
        if (busy20 !== 1'b1 || busy21 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_busy: got busy@20=%b busy@21=%b expected 1/0", busy20, busy21);
        end
        tests_run++;
        if (dc !== 0 || bus.hi !== 32'hA || bus.lo !== 32'hB) begin
            tests_failed++;
            $display("FAIL flush_result: got done_cnt=%0d hi=%h lo=%h expected 0/0000000a/0000000b", dc, bus.hi, bus.lo);
        end
        // flush in IDLE drops a start on the same edge
        @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.busa  = 32'h77;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        tests_run++;
        if (bus.hi !== 32'hA || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle_drop: got hi=%h busy=%b expected 0000000a/0", bus.hi, bus.busy);
        end
        // reserved opcode does nothing
        run_op(OP_NOP, 32'h99, 32'h1, bc, dc, di);
        tests_run++;
        if (bus.hi !== 32'hA || bus.lo !== 32'hB || bc !== 0 || dc !== 0) begin
            tests_failed++;
            $display("FAIL nop: got hi=%h lo=%h busy=%0d done=%0d expected a/b/0/0", bus.hi, bus.lo, bc, dc);
        end
        run_op(OP_DIVU, 32'd9, 32'd2, bc, dc, di);
        tests_run++;
        if (bus.lo !== 32'd4 || bus.hi !== 32'd1 || dc !== 1) begin
            tests_failed++;
            $display("FAIL divu_after_flush: got hi=%h lo=%h done=%0d expected 1/4/1", bus.hi, bus.lo, dc);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 3'b000;
        bus.busa     = 32'h0;
        bus.busb     = 32'h0;
        bus.flush    = 1'b0;
        test_reset();
        test_reset_midrun();
        test_mult();
        test_div();
        test_div_zero();
        test_start_while_busy();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of RegFile and consumes its busa/busb read ports as operands, beside the ALU.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO are exposed for the MFHI/MFLO writeback mux onto busw.
- The control unit stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH

Ports:
clk    input   1      rising-edge clock
reset  input   1      asynchronous, active-low reset
start  input   1      command strobe, sampled on clk rising edge
op     input   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
busa   input   WIDTH  operand A (rs) from RegFile
busb   input   WIDTH  operand B (rt) from RegFile
flush  input   1      synchronous abort of an in-flight operation
busy   output  1      operation in progress; new commands ignored
done   output  1      one-cycle pulse: HI/LO updated by MULT/DIV
hi     output  WIDTH  HI register
lo     output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi=lo=0; busy=0; done=0; iteration counter=0.
  - Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, FIX.
- busy = (state != IDLE), a registered-state decode with no combinational path from start.
- IDLE, start=1 with op=MTHI/MTLO:
  - hi (or lo) <= busa on that edge.
  - No busy, no done.
- IDLE, start=1 with op=MULT/MULTU/DIV/DIVU (edge E0):
  - Latch operands; state=RUN, counter=0.
  - Signed ops: latch magnitudes |busa| and |busb|, plus the sign flags.
    - Product/quotient negative iff the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Unsigned ops: operands taken raw.
- RUN: one iteration per cycle on E1..E32. Counter increments and wraps to FIX after WIDTH iterations.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle; remainder kept WIDTH+1 bits for the trial subtract.
- FIX (E33):
  - Apply sign correction (two's-complement negate: 64-bit for the product, separately for quotient and remainder).
  - Write hi/lo: MULT* gives hi=upper, lo=lower; DIV* gives lo=quotient, hi=remainder.
  - state=IDLE; done=1 for exactly the cycle after E33.
  - Latency: 33 clocks from accept to HI/LO valid; busy high for 33 cycles.
- Divide by zero (busb=0, DIV or DIVU):
  - Skip RUN; E0 -> FIX directly.
  - Result: lo=all-ones, hi=busa (raw dividend, both signed and unsigned).
  - done is high the cycle after E1; busy high for exactly 1 cycle.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. The magnitude algorithm with WIDTH truncation gives this naturally; no special case.
- start while busy: ignored entirely; operands and op are not re-latched.
- No-op opcodes: nothing happens.
- flush=1 on an edge with state RUN/FIX:
  - state=IDLE; hi/lo unchanged; no done.
  - flush has priority over the FIX write on the same edge.
  - flush in IDLE has no effect, and any start on that same edge is also dropped.
- hi/lo change only on the FIX write, MTHI/MTLO, or reset. They are stable and readable throughout RUN.
- done is never asserted for MTHI/MTLO, a flush, or a reset.

Test Plan:
1. reset=0 mid-RUN of a MULT started from hi=lo=0x12345678 -> hi=lo=0, busy=0 immediately (before the next clk edge); after release, an MTLO with busa=0x5 -> lo=0x00000005 on the next edge.
2. MULT busa=0xFFFFFFFE, busb=0x00000003 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle. MULTU busa=busb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. DIV busa=0xFFFFFFF9 (-7), busb=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU busa=100, busb=7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU busa=0x64, busb=0 -> busy exactly 1 cycle, done the next cycle, lo=0xFFFFFFFF, hi=0x00000064.
5. MULT 3*5; at cycle 10 pulse start with op=MTHI, busa=0xDEAD -> MTHI ignored; final hi=0, lo=15; done pulses exactly once.
6. Preload hi=0xA, lo=0xB via MTHI/MTLO; start DIVU 9/2; assert flush at cycle 20 -> busy falls next edge, no done, hi=0xA, lo=0xB; a following DIVU 9/2 -> lo=4, hi=1.
